// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: two-requester round-robin arbiter feeding a one-entry
// immediate-extension result register (zero/sign/LUI/branch-offset modes).
module imm_ext_arbiter #(
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_imm,
    input  logic [1:0]  req0_mode,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_imm,
    input  logic [1:0]  req1_mode,
    output logic        req1_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_src,
    output logic [7:0]  stall_cnt
);

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_src_q, out_src_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic        last_q, last_d;  // index of the most recent grant

    logic        slot_free;
    logic        grant0, grant1, any_grant;
    logic        any_valid;
    logic [15:0] sel_imm;
    logic [1:0]  sel_mode;

    function automatic logic [31:0] extend(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] sext;
        sext = {{16{imm[15]}}, imm};
        unique case (mode)
            2'b00:   extend = {16'h0000, imm};
            2'b01:   extend = sext;
            2'b10:   extend = {imm, 16'h0000};
            default: extend = sext << BR_SHIFT;
        endcase
    endfunction

    // Arbitration: ready reflects who would win, independent of own valid
    // except that a valid rival with priority takes the slot.
    always_comb begin
        slot_free  = !out_valid_q || out_ready;
        req0_ready = !Rst && slot_free && (!req1_valid || last_q);
        req1_ready = !Rst && slot_free && (!req0_valid || !last_q);
        grant0     = req0_valid && req0_ready;
        grant1     = req1_valid && req1_ready;
        any_grant  = grant0 || grant1;
        any_valid  = req0_valid || req1_valid;
        sel_imm    = grant1 ? req1_imm : req0_imm;
        sel_mode   = grant1 ? req1_mode : req0_mode;
    end

    // Next-state for result register, grant pointer and stall counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        last_d      = last_q;
        stall_cnt_d = stall_cnt_q;
        if (any_grant) begin
            out_valid_d = 1'b1;
            out_data_d  = extend(sel_imm, sel_mode);
            out_src_d   = grant1;
            last_d      = grant1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (any_valid && !any_grant && stall_cnt_q != 8'hFF) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    // State registers; reset clears the held result without waiting for Clk.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            out_src_q   <= 1'b0;
            stall_cnt_q <= 8'h00;
            last_q      <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            stall_cnt_q <= stall_cnt_d;
            last_q      <= last_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_src   = out_src_q;
        stall_cnt = stall_cnt_q;
    end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed self-checking bench for imm_ext_arbiter.
module tb_imm_ext_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [15:0] req0_imm = 16'h0, req1_imm = 16'h0;
    logic [1:0]  req0_mode = 2'b00, req1_mode = 2'b00;
    logic        req0_ready, req1_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_src;
    logic [7:0]  stall_cnt;

    int n_total = 0;
    int n_bad   = 0;

    imm_ext_arbiter #(.BR_SHIFT(2)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .req0_valid (req0_valid),
        .req0_imm   (req0_imm),
        .req0_mode  (req0_mode),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_imm   (req1_imm),
        .req1_mode  (req1_mode),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .stall_cnt  (stall_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Single-shot request on one port; result checked one cycle after acceptance.
    task automatic send(input logic src, input logic [15:0] imm, input logic [1:0] mode,
                        input logic [31:0] exp, input string tag);
        if (src) begin
            req1_valid = 1'b1; req1_imm = imm; req1_mode = mode;
        end else begin
            req0_valid = 1'b1; req0_imm = imm; req0_mode = mode;
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_src"}, {31'b0, out_src}, {31'b0, src});
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_src", {31'b0, out_src}, 32'd0);
        chk("rst_stall", {24'b0, stall_cnt}, 32'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst_rdy0", {31'b0, req0_ready}, 32'd0);
        chk("rst_rdy1", {31'b0, req1_ready}, 32'd0);
        Rst = 1'b0;

        // Round-robin with both valid, consumer always ready
        req0_imm = 16'h0001; req0_mode = 2'b00;
        req1_imm = 16'h0002; req1_mode = 2'b00;
        out_ready = 1'b1;
        #1;
        chk("rr_rdy0_first", {31'b0, req0_ready}, 32'd1);
        chk("rr_rdy1_first", {31'b0, req1_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_src", {31'b0, out_src}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_valid", {31'b0, out_valid}, 32'd1);
            chk("rr_data", out_data, (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_stall", {24'b0, stall_cnt}, 32'd0);
        tick();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // Extension modes
        send(1'b0, 16'h8001, 2'b01, 32'hFFFF8001, "sext");
        send(1'b0, 16'hFFFE, 2'b00, 32'h0000FFFE, "zext");
        send(1'b0, 16'hFFFE, 2'b10, 32'hFFFE0000, "lui");
        send(1'b1, 16'hFFFE, 2'b11, 32'hFFFFFFF8, "br");
        send(1'b1, 16'h4001, 2'b11, 32'h00010004, "br_pos");

        // Back-pressure: result held, both requesters waiting
        send(1'b0, 16'h1234, 2'b00, 32'h00001234, "hold_load");
        out_ready = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_data", out_data, 32'h00001234);
            chk("hold_src", {31'b0, out_src}, 32'd0);
        end
        chk("hold_rdy0", {31'b0, req0_ready}, 32'd0);
        chk("hold_rdy1", {31'b0, req1_ready}, 32'd0);
        chk("hold_stall", {24'b0, stall_cnt}, 32'd3);

        // Saturation of the stall counter
        req1_valid = 1'b0;
        for (int i = 0; i < 250; i++) tick();
        chk("stall_253", {24'b0, stall_cnt}, 32'd253);
        for (int i = 0; i < 50; i++) tick();
        chk("stall_sat", {24'b0, stall_cnt}, 32'hFF);
        chk("sat_valid", {31'b0, out_valid}, 32'd1);

        // Asynchronous reset mid-transfer; last grant was req0
        req1_valid = 1'b1;
        #2;
        Rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_data", out_data, 32'h0);
        chk("arst_stall", {24'b0, stall_cnt}, 32'd0);
        chk("arst_rdy0", {31'b0, req0_ready}, 32'd0);
        chk("arst_rdy1", {31'b0, req1_ready}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        out_ready = 1'b1;
        req0_imm = 16'h0005; req0_mode = 2'b00;
        req1_imm = 16'h0006; req1_mode = 2'b00;
        #1;
        chk("post_rdy0", {31'b0, req0_ready}, 32'd1);
        chk("post_rdy1", {31'b0, req1_ready}, 32'd0);
        tick();
        chk("post_src", {31'b0, out_src}, 32'd0);
        chk("post_data", out_data, 32'h5);
        chk("post_valid", {31'b0, out_valid}, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 The block SHALL have parameter BR_SHIFT, default 2, giving the left-shift amount applied in branch-offset mode.
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port Rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 each, meaning requester n presents an operand.
REQ-005 The block SHALL have ports req0_imm / req1_imm, input, 16 each, the raw immediate field.
REQ-006 The block SHALL have ports req0_mode / req1_mode, input, 2 each: 00 zero-extend, 01 sign-extend, 10 LUI (imm<<16), 11 branch offset (sign-extend then <<BR_SHIFT).
REQ-007 The block SHALL have ports req0_ready / req1_ready, output, 1 each, meaning the request is accepted this cycle when valid&ready.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the result register holds an undelivered result.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle when out_valid&out_ready.
REQ-010 The block SHALL have port out_data, output, 32, the extended result.
REQ-011 The block SHALL have port out_src, output, 1, giving the requester index that produced out_data.
REQ-012 The block SHALL have port stall_cnt, output, 8, counting cycles in which a valid request was not accepted.

Function
REQ-013 The block SHALL hold one result register; "slot free" SHALL mean out_valid==0 or out_ready==1 in that cycle.
REQ-014 The block SHALL grant at most one requester per cycle, and only while the slot is free.
REQ-015 When exactly one requester is valid and the slot is free, the block SHALL grant it.
REQ-016 When both requesters are valid and the slot is free, the block SHALL grant the requester not granted most recently (round-robin); a last-grant pointer SHALL update only on an actual grant.
REQ-017 reqN_ready SHALL be combinational: high only for the requester the block would grant this cycle; ready SHALL NOT depend on that requester's own valid except through the arbitration tie-break.
REQ-018 On grant, the block SHALL load out_data, out_src and set out_valid on the next edge, giving a latency of 1 cycle from acceptance to out_valid.
REQ-019 Mode 00 SHALL produce {16'h0000, imm}.
REQ-020 Mode 01 SHALL produce {16{imm[15]}, imm}.
REQ-021 Mode 10 SHALL produce {imm, 16'h0000}.
REQ-022 Mode 11 SHALL produce the 32-bit sign-extension shifted left by BR_SHIFT, with bits shifted out discarded and zero fill.
REQ-023 When out_valid&out_ready and no grant occurs, out_valid SHALL clear on the next edge.
REQ-024 A simultaneous drain and grant SHALL replace the result back-to-back with out_valid held high, sustaining one result per cycle.
REQ-025 While out_valid and !out_ready, out_data and out_src SHALL remain stable.
REQ-026 stall_cnt SHALL increment by one for each cycle in which at least one requester is valid but no requester is accepted, and SHALL saturate at 8'hFF.

Reset
REQ-027 While Rst is high, out_valid SHALL be 0, out_data SHALL be 32'h0, out_src SHALL be 0, stall_cnt SHALL be 0, and the last-grant pointer SHALL be 1, so that requester 0 wins the first tie.
REQ-028 Assertion of Rst mid-transfer SHALL discard any held result immediately, without waiting for Clk; req0_ready and req1_ready SHALL be 0 while Rst is high.

Verification
REQ-029 The bench SHALL drive req0 only, imm=16'h8001, mode=01, out_ready=1, and check out_data=32'hFFFF8001, out_src=0 one cycle after acceptance.
REQ-030 The bench SHALL cover modes 00, 10 and 11 with imm=16'hFFFE: check 32'h0000FFFE, 32'hFFFE0000, and 32'hFFFFFFF8 respectively, the last with BR_SHIFT=2.
REQ-031 The bench SHALL hold both requesters valid for 4 cycles after reset with out_ready=1, and check the grant order 0,1,0,1 and out_valid continuously high.
REQ-032 The bench SHALL set out_ready=0 with a result held and both requesters valid for 3 cycles, then check that both readys are 0, out_data is stable, and stall_cnt=3.
REQ-033 The bench SHALL keep a request valid with out_ready=0 for 300 cycles, and check that stall_cnt saturates at 8'hFF.
REQ-034 The bench SHALL assert Rst asynchronously between edges while out_valid=1, and check that out_valid drops immediately and that the first post-reset tie is granted to requester 0.
